// File: rtl/sha_sched_pkg.sv
// Shared types and defaults for the SHA job scheduler.
// State encoding, parameter defaults and a width helper.
package sha_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 1_000_000;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/job_fifo.sv
// Synchronous job FIFO with same-cycle push/pop.
// Count is one bit wider than the pointers.
module job_fifo
  import sha_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [$clog2(DEPTH):0] count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sha_job_scheduler.sv
// Queues scanned barcode words and issues them to the SHA core,
// one job at a time, with dedup, timeout and status counters.
module sha_job_scheduler
  import sha_sched_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter bit DEDUP_EN       = 1'b1
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              SCAN_VALID,
  input  logic [DATA_W-1:0] SCAN_DATA,
  input  logic              SHA_READY,
  input  logic              SHA_DONE,
  output logic [DATA_W-1:0] SHA_DATA,
  output logic              SHA_START,
  output logic              BUSY,
  output logic [$clog2(DEPTH):0] FIFO_COUNT,
  output logic [15:0]       JOBS_DONE,
  output logic [7:0]        DROP_COUNT,
  output logic              ERR_TIMEOUT
);

  localparam int TW = clog2_min1(TIMEOUT_CYCLES);

  state_t            state;
  logic [TW-1:0]     timer;
  logic [DATA_W-1:0] last_word;
  logic              last_valid;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              dup;
  logic              pop;
  logic              push;
  logic              drop;

  assign dup  = DEDUP_EN && last_valid && (SCAN_DATA == last_word);
  assign pop  = (state == IDLE) && !empty && SHA_READY;
  assign push = SCAN_VALID && !dup && (!full || pop);
  assign drop = SCAN_VALID && !dup && full && !pop;
  assign BUSY = (state != IDLE);

  job_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (CLOCK_50),
    .rst_n(RESET),
    .push (push),
    .din  (SCAN_DATA),
    .pop  (pop),
    .head (head),
    .count(FIFO_COUNT),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      state       <= IDLE;
      timer       <= '0;
      last_word   <= '0;
      last_valid  <= 1'b0;
      SHA_DATA    <= '0;
      SHA_START   <= 1'b0;
      JOBS_DONE   <= '0;
      DROP_COUNT  <= '0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      if (push) begin
        last_word  <= SCAN_DATA;
        last_valid <= 1'b1;
      end
      if (drop && DROP_COUNT != 8'hFF) begin
        DROP_COUNT <= DROP_COUNT + 8'd1;
      end
      SHA_START <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            SHA_DATA  <= head;
            SHA_START <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over a coincident timeout.
          if (SHA_DONE) begin
            JOBS_DONE <= JOBS_DONE + 16'd1;
            state     <= DRAIN;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            ERR_TIMEOUT <= 1'b1;
            state       <= DRAIN;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DRAIN: begin
          if (!SHA_DONE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Self-checking bench for sha_job_scheduler: directed vectors,
// corner sequences and a randomized run against a queue model.
module tb_sha_job_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_valid = 1'b0;
  logic [31:0] scan_data = '0;
  logic        sha_ready = 1'b0;
  logic        sha_done = 1'b0;
  logic [31:0] sha_data;
  logic        sha_start;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [15:0] jobs_done;
  logic [7:0]  drop_count;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha_job_scheduler #(
    .DATA_W        (32),
    .DEPTH         (4),
    .TIMEOUT_CYCLES(16),
    .DEDUP_EN      (1'b1)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst_n),
    .SCAN_VALID (scan_valid),
    .SCAN_DATA  (scan_data),
    .SHA_READY  (sha_ready),
    .SHA_DONE   (sha_done),
    .SHA_DATA   (sha_data),
    .SHA_START  (sha_start),
    .BUSY       (busy),
    .FIFO_COUNT (fifo_count),
    .JOBS_DONE  (jobs_done),
    .DROP_COUNT (drop_count),
    .ERR_TIMEOUT(err_timeout)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [2:0]  cnt;
    logic [7:0]  drop;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    scan_valid = 1'b0;
    sha_done = 1'b0;
    sha_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] w);
    scan_valid = 1'b1;
    scan_data = w;
    tick();
    scan_valid = 1'b0;
  endtask

  task automatic wait_start(input string name, input logic [31:0] exp);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sha_start) break;
    end
    check({name, "_start"}, sha_start, 1);
    check({name, "_data"}, sha_data, exp);
  endtask

  task automatic serve(input int d);
    repeat (d) tick();
    sha_done = 1'b1;
    repeat (2) tick();
    sha_done = 1'b0;
  endtask

  logic [31:0] exp_order [4];
  logic [31:0] q [$];
  logic [31:0] last_w;
  logic        last_v;
  int          drops;
  int          jobs;
  int          cd;
  int          hold;
  logic        outstanding;
  logic        pv;
  logic        pr;
  logic [31:0] pd;
  int          n;

  initial begin
    tbl[0]  = '{1'b1, 32'hA1, 3'd1, 8'd0};
    tbl[1]  = '{1'b1, 32'hA1, 3'd1, 8'd0};
    tbl[2]  = '{1'b0, 32'hA1, 3'd1, 8'd0};
    tbl[3]  = '{1'b1, 32'hB2, 3'd2, 8'd0};
    tbl[4]  = '{1'b1, 32'hC3, 3'd3, 8'd0};
    tbl[5]  = '{1'b1, 32'hC3, 3'd3, 8'd0};
    tbl[6]  = '{1'b1, 32'hD4, 3'd4, 8'd0};
    tbl[7]  = '{1'b1, 32'hE5, 3'd4, 8'd1};
    tbl[8]  = '{1'b1, 32'hF6, 3'd4, 8'd2};
    tbl[9]  = '{1'b1, 32'hF6, 3'd4, 8'd3};
    tbl[10] = '{1'b1, 32'hD4, 3'd4, 8'd3};
    exp_order[0] = 32'hA1;
    exp_order[1] = 32'hB2;
    exp_order[2] = 32'hC3;
    exp_order[3] = 32'hD4;

    // Reset state and single-job latency
    do_reset();
    check("rst_data", sha_data, 0);
    check("rst_start", sha_start, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_jobs", jobs_done, 0);
    check("rst_drop", drop_count, 0);
    check("rst_err", err_timeout, 0);
    sha_ready = 1'b1;
    push(32'h0000_1234);
    check("t1_start_t1", sha_start, 0);
    check("t1_count", fifo_count, 1);
    tick();
    check("t1_start_t2", sha_start, 1);
    check("t1_data", sha_data, 32'h0000_1234);
    check("t1_busy", busy, 1);
    tick();
    check("t1_start_pulse", sha_start, 0);
    repeat (4) tick();
    sha_done = 1'b1;
    tick();
    check("t1_jobs", jobs_done, 1);
    check("t1_drain_busy", busy, 1);
    sha_done = 1'b0;
    tick();
    check("t1_idle", busy, 0);

    // Dedup of back-to-back duplicates
    do_reset();
    push(32'hAB);
    push(32'hAB);
    check("t2_count", fifo_count, 1);
    sha_ready = 1'b1;
    wait_start("t2_ab", 32'hAB);
    serve(2);
    sha_ready = 1'b0;
    push(32'hCD);
    push(32'hAB);
    check("t2_count2", fifo_count, 2);
    sha_ready = 1'b1;
    wait_start("t2_cd", 32'hCD);
    serve(2);
    wait_start("t2_ab2", 32'hAB);
    serve(2);
    repeat (4) tick();
    check("t2_jobs", jobs_done, 3);

    // Table: dedup, full FIFO drops, saturation-free counting
    do_reset();
    foreach (tbl[i]) begin
      scan_valid = tbl[i].v;
      scan_data = tbl[i].d;
      tick();
      check($sformatf("tbl%0d_count", i), fifo_count, tbl[i].cnt);
      check($sformatf("tbl%0d_drop", i), drop_count, tbl[i].drop);
    end
    scan_valid = 1'b0;
    sha_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start($sformatf("t3_job%0d", i), exp_order[i]);
      serve(1);
    end
    repeat (6) tick();
    check("t3_jobs", jobs_done, 4);
    check("t3_empty", fifo_count, 0);
    check("t3_idle", busy, 0);

    // Timeout abort, next job still issues
    do_reset();
    push(32'h11);
    push(32'h22);
    sha_ready = 1'b1;
    wait_start("t4_first", 32'h11);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (err_timeout) break;
    end
    check("t4_wait_len", n, 17);
    check("t4_err", err_timeout, 1);
    check("t4_jobs0", jobs_done, 0);
    wait_start("t4_next", 32'h22);
    serve(2);
    repeat (2) tick();
    check("t4_err_sticky", err_timeout, 1);
    check("t4_jobs1", jobs_done, 1);

    // Reset mid-job with jobs queued
    sha_ready = 1'b1;
    push(32'h51);
    push(32'h52);
    push(32'h53);
    push(32'h54);
    tick();
    check("t5_count", fifo_count, 3);
    check("t5_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sha_ready = 1'b0;
    check("t5_data", sha_data, 0);
    check("t5_start", sha_start, 0);
    check("t5_busy0", busy, 0);
    check("t5_count0", fifo_count, 0);
    check("t5_jobs", jobs_done, 0);
    check("t5_err", err_timeout, 0);
    tick();
    check("t5_no_start", sha_start, 0);
    push(32'h54);
    check("t5_repush", fifo_count, 1);

    // Full FIFO, issue pop and push at the same edge
    do_reset();
    push(32'h61);
    push(32'h62);
    push(32'h63);
    push(32'h64);
    check("t6_full", fifo_count, 4);
    scan_valid = 1'b1;
    scan_data = 32'h66;
    sha_ready = 1'b1;
    tick();
    scan_valid = 1'b0;
    check("t6_start", sha_start, 1);
    check("t6_data", sha_data, 32'h61);
    check("t6_count", fifo_count, 4);
    check("t6_drop", drop_count, 0);
    serve(1);
    wait_start("t6_j2", 32'h62);
    serve(1);
    wait_start("t6_j3", 32'h63);
    serve(1);
    wait_start("t6_j4", 32'h64);
    serve(1);
    wait_start("t6_j5", 32'h66);
    serve(1);

    // Randomized run against a queue-level model
    do_reset();
    q.delete();
    last_v = 1'b0;
    last_w = '0;
    drops = 0;
    jobs = 0;
    outstanding = 1'b0;
    cd = 0;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      scan_valid = (c < 2700) && ($urandom_range(0, 2) == 0);
      scan_data = 32'h1000 + $urandom_range(0, 5);
      sha_ready = (c >= 2700) || ($urandom_range(0, 3) != 0);
      pv = scan_valid;
      pd = scan_data;
      pr = sha_ready;
      tick();
      check("rnd_jobs", jobs_done, jobs);
      if (sha_start) begin
        check("rnd_issue_ready", pr, 1);
        check("rnd_one_job", outstanding, 0);
        check("rnd_nonempty", q.size() > 0, 1);
        if (q.size() > 0) check("rnd_data", sha_data, q.pop_front());
        outstanding = 1'b1;
        cd = $urandom_range(1, 8);
      end
      if (pv && !(last_v && pd == last_w)) begin
        if (q.size() < 4) begin
          q.push_back(pd);
          last_w = pd;
          last_v = 1'b1;
        end else if (drops < 255) begin
          drops++;
        end
      end
      check("rnd_count", fifo_count, q.size());
      check("rnd_drop", drop_count, drops);
      if (outstanding && !sha_done && !sha_start) begin
        cd--;
        if (cd == 0) begin
          sha_done = 1'b1;
          jobs++;
          hold = $urandom_range(1, 3);
        end
      end else if (sha_done) begin
        hold--;
        if (hold == 0) begin
          sha_done = 1'b0;
          outstanding = 1'b0;
        end
      end
    end
    check("rnd_drained", q.size(), 0);
    check("rnd_err", err_timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
